apb_rx: RTL

//  - UART receiver, downstream of apb_tx; consumes its serial tx_out on rx_in.
//  - Oversamples with the same baud divisor, recovers 8- or 10-bit LSB-first frames (start, data, stop).
//  - Presents each good word with a 1-cycle rx_valid pulse; flags a bad stop bit with frame_err.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/apb_rx.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int BAUD_W      = 20;
  localparam int DATA_W      = 10;
  localparam int SYNC_STAGES = 2;

  localparam logic [BAUD_W-1:0] BAUD_RST = BAUD_W'(16);
  localparam logic              MODE_8   = 1'b0;
  localparam logic              MODE_10  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // A divisor below 2 would leave no room for a half-bit wait.
  function automatic logic [BAUD_W-1:0] clamp_baud(input logic [BAUD_W-1:0] b);
    return (b < BAUD_W'(2)) ? BAUD_W'(2) : b;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial line plus falling-edge detect.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              rx_d;

  // Flops preset high so a reset never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
      rx_d  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], rx_in};
      rx_d  <= chain[STAGES-1];
    end
  end

  assign rx   = chain[STAGES-1];
  assign fall = rx_d & ~rx;

endmodule

// File: rtl/apb_rx.sv
// UART receiver: oversampled start/data/stop recovery of 8- or 10-bit LSB-first frames.
module apb_rx
  import uart_pkg::*;
#(
  parameter int BAUD_W      = uart_pkg::BAUD_W,
  parameter int DATA_W      = uart_pkg::DATA_W,
  parameter int SYNC_STAGES = uart_pkg::SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              set,
  input  logic              mode,
  input  logic [BAUD_W-1:0] baud,
  input  logic              rx_in,
  output logic [DATA_W-1:0] dout,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              rx_busy
);

  rx_state_t         state, state_next;
  logic              mode_r;
  logic [BAUD_W-1:0] baud_r;
  logic [BAUD_W-1:0] cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              rx, fall, en;
  logic              tick_half, tick_bit, last_bit;
  logic              cnt_clr, shift_en, bit_inc, load_word, valid_next, err_next;
  logic [DATA_W-1:0] word;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx_in(rx_in),
    .rx   (rx),
    .fall (fall)
  );

  assign en        = sel & set;
  assign tick_half = (cnt == (baud_r >> 1) - BAUD_W'(1));
  assign tick_bit  = (cnt == baud_r - BAUD_W'(1));
  assign last_bit  = (bit_cnt == (mode_r == MODE_10 ? 4'(DATA_W - 1) : 4'd7));
  // 8-bit frames land in the top of the shift register; right-align them.
  assign word      = (mode_r == MODE_10) ? shreg : (shreg >> (DATA_W - 8));

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    bit_inc    = 1'b0;
    load_word  = 1'b0;
    valid_next = 1'b0;
    err_next   = 1'b0;
    unique case (state)
      IDLE:  if (fall) state_next = START;
      START: if (tick_half) state_next = rx ? IDLE : DATA;
      DATA:
        if (tick_bit) begin
          shift_en = 1'b1;
          if (last_bit) state_next = STOP;
          else          bit_inc    = 1'b1;
        end
      STOP:
        if (tick_bit) begin
          state_next = IDLE;
          load_word  = rx;
          valid_next = rx;
          err_next   = ~rx;
        end
      default: state_next = IDLE;
    endcase
    // Dropping enable abandons any frame in progress without a pulse.
    if (!en) begin
      state_next = IDLE;
      shift_en   = 1'b0;
      bit_inc    = 1'b0;
      load_word  = 1'b0;
      valid_next = 1'b0;
      err_next   = 1'b0;
    end
  end

  assign cnt_clr = (state_next != state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_r    <= MODE_8;
      baud_r    <= BAUD_RST;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dout      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      rx_valid  <= valid_next;
      frame_err <= err_next;
      if (sel && !set) begin
        mode_r <= mode;
        baud_r <= clamp_baud(baud);
      end
      if (cnt_clr || tick_bit) cnt <= '0;
      else                     cnt <= cnt + BAUD_W'(1);
      if (cnt_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en)  shreg <= {rx, shreg[DATA_W-1:1]};
      if (load_word) dout  <= word;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
